// File: rtl/semaphore_multi.sv
// semaphore_multi: multi-node lock arbiter guarding a bounded coin counter.
// Nodes request the lock with prioritised START words. Only the owner's
// commands (POST/WAIT/QUERY/STOP) are decoded, each executing once per word
// change. An optional hold timer releases an idle owner.
//
// state    | meaning
// ---------+-----------------------------------------------------------
// UNLOCKED | no owner; out forced to 0; any START is arbitrated
// LOCKED   | owner_q holds the lock; only its word changes are executed
module semaphore_multi #(
  parameter int NODES      = 4,
  parameter int MAX_COINS  = 10,
  parameter int INIT_COINS = 0,
  parameter int TIMEOUT    = 0
) (
  input  logic                  CLK,
  input  logic                  RST_N,
  input  logic [16*NODES-1:0]   in_op,
  output logic [15:0]           out,
  output logic [2:0]            lock_owner,
  output logic                  locked,
  output logic [7:0]            coins
);

  localparam logic [15:0] OP_STOP  = 16'hFEFF;
  localparam logic [15:0] OP_POST  = 16'h0E10;
  localparam logic [15:0] OP_WAIT  = 16'h0E20;
  localparam logic [15:0] OP_QUERY = 16'h0E30;

  localparam logic [7:0]  MAX_C     = 8'(MAX_COINS);
  localparam logic [7:0]  INIT_C    = 8'(INIT_COINS);
  localparam logic [2:0]  RR_INIT   = 3'(NODES - 1);
  // Down-counter reload: expiry is the edge on which the counter reads 0,
  // which lands exactly TIMEOUT idle cycles after the last reload.
  localparam logic [15:0] HOLD_LOAD = (TIMEOUT > 0) ? 16'(TIMEOUT - 1) : 16'd0;

  typedef enum logic {
    UNLOCKED = 1'b0,
    LOCKED   = 1'b1
  } state_t;

  state_t              state_q, state_d;
  logic [2:0]          owner_q, owner_d;
  logic [2:0]          rr_q, rr_d;
  logic [15:0]         out_q, out_d;
  logic [15:0]         hold_q, hold_d;
  logic [7:0]          coins_q, coins_d;
  logic [16*NODES-1:0] prev_q;

  logic [3:0]          best_pri;
  logic                grant_vld;
  logic [2:0]          grant_idx;
  int                  idx;

  logic [15:0]         owner_word;
  logic [15:0]         owner_prev;
  logic [15:0]         owner_1h;
  logic                cmd_new;

  function automatic logic is_start(input logic [15:0] w);
    return (w[15:8] == 8'hFE) && (w[7:4] == 4'h0) && (w[3:0] != 4'h0);
  endfunction

  // Highest START priority, then round-robin among ties starting after rr_q.
  always_comb begin
    best_pri  = 4'h0;
    grant_vld = 1'b0;
    grant_idx = 3'd0;
    idx       = 0;
    for (int n = 0; n < NODES; n++) begin
      if (is_start(in_op[16*n +: 16]) && (in_op[16*n +: 4] > best_pri)) begin
        best_pri = in_op[16*n +: 4];
      end
    end
    for (int k = 1; k <= NODES; k++) begin
      idx = int'(rr_q) + k;
      if (idx >= NODES) idx = idx - NODES;
      if (!grant_vld && (best_pri != 4'h0) && is_start(in_op[16*idx +: 16]) &&
          (in_op[16*idx +: 4] == best_pri)) begin
        grant_vld = 1'b1;
        grant_idx = 3'(idx);
      end
    end
  end

  assign owner_word = in_op[16*owner_q +: 16];
  assign owner_prev = prev_q[16*owner_q +: 16];
  assign owner_1h   = 16'd1 << owner_q;
  assign cmd_new    = (owner_word != owner_prev);

  // Next-state, response and counter updates.
  always_comb begin
    state_d = state_q;
    owner_d = owner_q;
    rr_d    = rr_q;
    out_d   = out_q;
    hold_d  = hold_q;
    coins_d = coins_q;
    unique case (state_q)
      UNLOCKED: begin
        out_d = 16'h0000;
        if (grant_vld) begin
          state_d = LOCKED;
          owner_d = grant_idx;
          rr_d    = grant_idx;
          hold_d  = HOLD_LOAD;
        end
      end
      LOCKED: begin
        if (cmd_new && (owner_word == OP_STOP)) begin
          state_d = UNLOCKED;
          owner_d = 3'd0;
          out_d   = 16'h0000;
          hold_d  = 16'd0;
        end else if (cmd_new && (owner_word == OP_POST)) begin
          hold_d = HOLD_LOAD;
          if (coins_q < MAX_C) begin
            coins_d = coins_q + 8'd1;
            out_d   = 16'h0E00 | owner_1h;
          end else begin
            out_d   = 16'h1E00 | owner_1h;
          end
        end else if (cmd_new && (owner_word == OP_WAIT)) begin
          hold_d = HOLD_LOAD;
          if (coins_q != 8'd0) begin
            coins_d = coins_q - 8'd1;
            out_d   = 16'h0E00 | owner_1h;
          end else begin
            out_d   = 16'h2E00 | owner_1h;
          end
        end else if (cmd_new && (owner_word == OP_QUERY)) begin
          hold_d = HOLD_LOAD;
          out_d  = 16'h4E00 | {8'h00, coins_q};
        end else if ((TIMEOUT > 0) && (hold_q == 16'd0)) begin
          state_d = UNLOCKED;
          owner_d = 3'd0;
          out_d   = 16'h8E00 | owner_1h;
        end else if (hold_q != 16'd0) begin
          hold_d = hold_q - 16'd1;
        end
      end
      default: state_d = UNLOCKED;
    endcase
  end

  // State register; reset drops any lock or half-done command.
  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      state_q <= UNLOCKED;
      owner_q <= 3'd0;
      rr_q    <= RR_INIT;
      out_q   <= 16'h0000;
      hold_q  <= 16'd0;
      coins_q <= INIT_C;
      prev_q  <= '0;
    end else begin
      state_q <= state_d;
      owner_q <= owner_d;
      rr_q    <= rr_d;
      out_q   <= out_d;
      hold_q  <= hold_d;
      coins_q <= coins_d;
      prev_q  <= in_op;
    end
  end

  assign out        = out_q;
  assign lock_owner = owner_q;
  assign locked     = (state_q == LOCKED);
  assign coins      = coins_q;

endmodule

// File: tb/tb_semaphore_multi.sv
// Bench for semaphore_multi: directed scenarios then random traffic, every
// cycle predicted by a behavioural model and checked by a queue-fed monitor.
module tb_semaphore_multi;

  localparam int NODES      = 4;
  localparam int MAX_COINS  = 10;
  localparam int INIT_COINS = 2;
  localparam int TIMEOUT    = 8;

  localparam logic [15:0] STOP_W  = 16'hFEFF;
  localparam logic [15:0] POST_W  = 16'h0E10;
  localparam logic [15:0] WAIT_W  = 16'h0E20;
  localparam logic [15:0] QUERY_W = 16'h0E30;

  logic                CLK = 1'b0;
  logic                RST_N = 1'b0;
  logic [16*NODES-1:0] in_op = '0;
  logic [15:0]         out;
  logic [2:0]          lock_owner;
  logic                locked;
  logic [7:0]          coins;

  semaphore_multi #(
    .NODES(NODES), .MAX_COINS(MAX_COINS), .INIT_COINS(INIT_COINS), .TIMEOUT(TIMEOUT)
  ) dut (
    .CLK(CLK), .RST_N(RST_N), .in_op(in_op),
    .out(out), .lock_owner(lock_owner), .locked(locked), .coins(coins)
  );

  always #5 CLK = ~CLK;

  typedef struct {
    logic [15:0] out;
    logic [2:0]  owner;
    logic        locked;
    logic [7:0]  coins;
    string       tag;
  } exp_t;

  exp_t  exp_q[$];
  int    n_cmp = 0;
  int    n_bad = 0;
  event  sample_ev;
  string cur_tag = "reset";

  // Reference model state
  bit          m_locked;
  int          m_owner, m_rr, m_idle, m_coins;
  logic [15:0] m_out;
  logic [15:0] m_prev[NODES];
  logic [15:0] w[NODES];

  function automatic logic [15:0] st(input int p);
    return 16'hFE00 | 16'(p);
  endfunction

  function automatic bit is_start(input logic [15:0] v);
    return (v[15:8] == 8'hFE) && (v[7:0] >= 8'd1) && (v[7:0] <= 8'd15);
  endfunction

  task automatic check_val(input string what, input logic [15:0] got, input logic [15:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s @%0t: got %h, expected %h", what, $time, got, exp);
    end
  endtask

  task automatic model_reset();
    m_locked = 0;
    m_owner  = 0;
    m_rr     = NODES - 1;
    m_idle   = 0;
    m_coins  = INIT_COINS;
    m_out    = 16'h0000;
    foreach (m_prev[i]) m_prev[i] = 16'h0000;
  endtask

  // One clock edge of the semaphore's rules, applied to the words in w[].
  task automatic model_step();
    logic [15:0] cur;
    logic [15:0] oh;
    int best;
    bit fresh;
    best = 0;
    if (!m_locked) begin
      m_out = 16'h0000;
      foreach (w[n]) if (is_start(w[n]) && int'(w[n][3:0]) > best) best = int'(w[n][3:0]);
      if (best > 0) begin
        for (int k = 1; k <= NODES; k++) begin
          int n;
          n = (m_rr + k) % NODES;
          if (is_start(w[n]) && int'(w[n][3:0]) == best) begin
            m_locked = 1;
            m_owner  = n;
            m_rr     = n;
            m_idle   = 0;
            break;
          end
        end
      end
    end else begin
      cur   = w[m_owner];
      fresh = (cur != m_prev[m_owner]);
      oh    = 16'(1 << m_owner);
      if (fresh && cur == STOP_W) begin
        m_locked = 0;
        m_out    = 16'h0000;
      end else if (fresh && cur == POST_W) begin
        m_idle = 0;
        if (m_coins < MAX_COINS) begin m_coins++; m_out = 16'h0E00 | oh; end
        else m_out = 16'h1E00 | oh;
      end else if (fresh && cur == WAIT_W) begin
        m_idle = 0;
        if (m_coins > 0) begin m_coins--; m_out = 16'h0E00 | oh; end
        else m_out = 16'h2E00 | oh;
      end else if (fresh && cur == QUERY_W) begin
        m_idle = 0;
        m_out  = 16'h4E00 | 16'(m_coins);
      end else begin
        m_idle++;
        if (TIMEOUT > 0 && m_idle >= TIMEOUT) begin
          m_locked = 0;
          m_out    = 16'h8E00 | oh;
        end
      end
    end
    foreach (w[i]) m_prev[i] = w[i];
  endtask

  task automatic push_exp();
    exp_t e;
    e.out    = m_out;
    e.owner  = m_locked ? 3'(m_owner) : 3'd0;
    e.locked = m_locked;
    e.coins  = 8'(m_coins);
    e.tag    = cur_tag;
    exp_q.push_back(e);
  endtask

  task automatic set_idle();
    foreach (w[i]) w[i] = 16'h0000;
  endtask

  // Apply w[] for the next rising edge and queue the predicted outcome.
  task automatic cycle();
    @(negedge CLK);
    for (int n = 0; n < NODES; n++) in_op[16*n +: 16] = w[n];
    model_step();
    push_exp();
  endtask

  // Assert reset between edges, check the async effect at once, then release.
  task automatic pulse_reset(input int n);
    @(negedge CLK);
    #1;
    RST_N = 1'b0;
    set_idle();
    in_op = '0;
    model_reset();
    #1;
    push_exp();
    -> sample_ev;
    #1;
    push_exp();
    repeat (n - 1) begin
      @(negedge CLK);
      push_exp();
    end
    @(negedge CLK);
    RST_N = 1'b1;
    model_step();
    push_exp();
  endtask

  // Sample point for registered outputs, away from the rising edge.
  always @(posedge CLK) begin
    #1;
    -> sample_ev;
  end

  // Monitor: pop the oldest prediction and compare it with the DUT.
  always @(sample_ev) begin
    exp_t e;
    if (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      n_cmp++;
      if (out !== e.out || lock_owner !== e.owner || locked !== e.locked || coins !== e.coins) begin
        n_bad++;
        $display("FAIL %s @%0t: got out=%h owner=%0d locked=%b coins=%0d, expected out=%h owner=%0d locked=%b coins=%0d",
                 e.tag, $time, out, lock_owner, locked, coins, e.out, e.owner, e.locked, e.coins);
      end
    end
  end

  initial begin
    int o;
    int r;
    model_reset();
    set_idle();
    repeat (2) begin
      @(negedge CLK);
      push_exp();
    end
    check_val("reset_out", out, 16'h0000);
    check_val("reset_locked", 16'(locked), 16'h0000);
    check_val("reset_owner", 16'(lock_owner), 16'h0000);
    check_val("reset_coins", 16'(coins), 16'(INIT_COINS));
    @(negedge CLK);
    RST_N = 1'b1;
    model_step();
    push_exp();

    cur_tag = "prio_grant";
    w[1] = st(3); w[2] = st(9);
    cycle();
    w[1] = 16'h0000;
    cycle();
    cur_tag = "owner_stop";
    w[2] = STOP_W;
    cycle();
    set_idle();
    cycle();

    cur_tag = "post_to_full";
    w[0] = st(1);
    cycle();
    repeat (9) begin
      w[0] = POST_W;  cycle();
      w[0] = 16'h0000; cycle();
    end
    cur_tag = "wait_from_full";
    w[0] = WAIT_W;  cycle();
    w[0] = QUERY_W; cycle();
    cur_tag = "wait_to_empty";
    repeat (9) begin
      w[0] = 16'h0000; cycle();
      w[0] = WAIT_W;  cycle();
    end
    cur_tag = "wait_held_empty";
    w[0] = 16'h0000; cycle();
    w[0] = WAIT_W;
    repeat (5) cycle();
    @(posedge CLK);
    #2;
    check_val("wait_held_empty_out", out, 16'h2E01);
    check_val("wait_held_empty_coins", 16'(coins), 16'h0000);
    w[0] = STOP_W; cycle();
    set_idle(); cycle();

    cur_tag = "reset_mid_lock";
    w[1] = st(4); cycle();
    repeat (5) begin
      w[1] = POST_W;  cycle();
      w[1] = 16'h0000; cycle();
    end
    w[1] = POST_W;
    pulse_reset(2);
    set_idle(); cycle(); cycle();

    cur_tag = "rr_tie";
    w[0] = st(5); w[3] = st(5);
    repeat (4) begin
      cycle();
      o = m_owner;
      w[o] = STOP_W;
      cycle();
      w[o] = st(5);
    end
    set_idle(); cycle();
    cycle();

    cur_tag = "timeout";
    w[2] = st(7); cycle();
    w[2] = 16'h0000;
    repeat (11) cycle();

    cur_tag = "random";
    for (int c = 0; c < 1500; c++) begin
      for (int n = 0; n < NODES; n++) begin
        r = int'($urandom_range(0, 99));
        if (r < 60)      w[n] = w[n];
        else if (r < 70) w[n] = st(int'($urandom_range(1, 15)));
        else if (r < 75) w[n] = STOP_W;
        else if (r < 83) w[n] = POST_W;
        else if (r < 91) w[n] = WAIT_W;
        else if (r < 95) w[n] = QUERY_W;
        else if (r < 98) w[n] = 16'h0000;
        else             w[n] = 16'($urandom);
      end
      if ($urandom_range(0, 299) == 0) begin
        cur_tag = "random_reset";
        pulse_reset(int'($urandom_range(1, 3)));
        cur_tag = "random";
      end else begin
        cycle();
      end
    end

    set_idle();
    cycle();
    repeat (3) @(posedge CLK);
    #2;
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
